// File: rtl/mem_if_arb.sv
// mem_if_arb: round-robin arbiter that funnels NUM_REQ mem_if requesters
// onto one downstream port toward the Wishbone bridge. Only one transaction
// is in flight downstream at a time; the response goes back to its owner
// through a zero-latency combinational path.
//
// Optional feature: define MEM_IF_ARB_TIMEOUT_EN to build the WAIT-state
// watchdog. When it fires, the owner gets a synthetic response
// (type 7, latched tid, data DEAD_BEEF). The late downstream response is
// then swallowed in DROP.
//
// Handshake rule on every port: a transfer happens on a rising clk_i edge
// where valid and ready are both 1. A valid source holds its payload
// stable until that edge. The arbiter never makes ready depend on payload
// contents.
//
// state_o and rr_ptr_o expose the FSM state and the round-robin pointer
// for debug. State encoding: IDLE=0, SEND=1, WAIT=2, DROP=3.
`timescale 1ns/1ps
module mem_if_arb #(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     s_req_valid,
  output logic [NUM_REQ-1:0]     s_req_ready,
  input  logic [NUM_REQ*87-1:0]  s_req,
  output logic [NUM_REQ-1:0]     s_resp_valid,
  input  logic [NUM_REQ-1:0]     s_resp_ready,
  output logic [50:0]            s_resp,
  output logic                   m_req_valid,
  input  logic                   m_req_ready,
  output logic [86:0]            m_req,
  input  logic                   m_resp_valid,
  output logic                   m_resp_ready,
  input  logic [50:0]            m_resp,
  output logic [1:0]             grant_o,
  output logic                   timeout_o,
  output logic [1:0]             state_o,
  output logic [1:0]             rr_ptr_o
);

`ifdef MEM_IF_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, DROP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;
`endif

  state_t state_q, state_d;
  logic [1:0]  rr_q;
  logic [1:0]  grant_q;
  logic [86:0] req_q;

  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic [2:0]           cand;
  logic                 win_found;
  logic [1:0]           win_idx;
  logic [NUM_REQ-1:0]   win_oh;
  logic [86:0]          win_pkt;
  logic [NUM_REQ-1:0]   own_oh;
  logic                 own_ready;
  logic                 txn_done;
  logic                 wd_fire;
  logic                 set_timeout;

  // Round-robin pick: rotate the valid vector so rr_q sits at bit 0 and
  // take the lowest set bit. Then map it back to a requester index.
  always_comb begin
    valid_dbl = {s_req_valid, s_req_valid};
    valid_rot = NUM_REQ'(valid_dbl >> rr_q);
    win_found = 1'b0;
    cand      = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        win_found = 1'b1;
        cand      = {1'b0, rr_q} + 3'(k);
      end
    end
    if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
    win_idx = cand[1:0];
  end

  // Decode the winner and the current owner into one-hot form, and mux
  // out the winner's packet and the owner's response-ready.
  always_comb begin
    win_oh    = '0;
    own_oh    = '0;
    win_pkt   = '0;
    own_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == 2'(i)) begin
        win_oh[i] = win_found;
        win_pkt   = s_req[i*87 +: 87];
      end
      if (grant_q == 2'(i)) begin
        own_oh[i] = 1'b1;
        own_ready = s_resp_ready[i];
      end
    end
  end

`ifdef MEM_IF_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  assign wd_fire = (state_q == WAIT) && (wd_q == WD_LAST);

  // Watchdog: cleared on entry to WAIT. It counts WAIT cycles that have no
  // response handshake, and holds once it reaches the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == SEND && state_d == WAIT) begin
        wd_q <= '0;
      end else if (state_q == WAIT && !wd_fire && !(m_resp_valid && own_ready)) begin
        wd_q <= wd_q + 1'b1;
      end
      if (set_timeout) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_fire = 1'b0;
  // Without the watchdog the flag is a constant zero.
  assign timeout_o = (TIMEOUT_CYC < 0);
`endif

  // FSM next state and all handshake outputs. Everything defaults to idle
  // and is forced quiet while reset is held.
  always_comb begin
    state_d      = state_q;
    s_req_ready  = '0;
    s_resp_valid = '0;
    s_resp       = '0;
    m_req_valid  = 1'b0;
    m_resp_ready = 1'b0;
    txn_done     = 1'b0;
    set_timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          s_req_ready = win_oh;
          state_d     = SEND;
        end
      end
      SEND: begin
        m_req_valid = 1'b1;
        if (m_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (wd_fire) begin
          s_resp_valid = own_oh;
          s_resp       = {3'd7, req_q[83:68], 32'hDEAD_BEEF};
          if (own_ready) begin
            txn_done    = 1'b1;
            set_timeout = 1'b1;
`ifdef MEM_IF_ARB_TIMEOUT_EN
            state_d     = DROP;
`endif
          end
        end else begin
          s_resp_valid = m_resp_valid ? own_oh : '0;
          s_resp       = m_resp;
          m_resp_ready = own_ready;
          if (m_resp_valid && own_ready) begin
            txn_done = 1'b1;
            state_d  = IDLE;
          end
        end
      end
`ifdef MEM_IF_ARB_TIMEOUT_EN
      DROP: begin
        m_resp_ready = 1'b1;
        if (m_resp_valid) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (rst_i) s_req_ready = '0;
  end

  // State, grant, latched packet and round-robin pointer. The pointer moves
  // only when a transaction completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 2'd0;
      grant_q <= 2'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_found) begin
        grant_q <= win_idx;
        req_q   <= win_pkt;
      end
      if (txn_done) begin
        rr_q <= (grant_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_q + 2'd1;
      end
    end
  end

  assign m_req    = req_q;
  assign grant_o  = grant_q;
  assign state_o  = state_q;
  assign rr_ptr_o = rr_q;

endmodule

// File: tb/tb_mem_if_arb.sv
// Directed bench for mem_if_arb with two requesters: a table of complete
// transactions, then hand-written response backpressure, reset during
// WAIT, and (when the watchdog is built) timeout sequences.
`timescale 1ns/1ps
module tb_mem_if_arb;
  localparam int NR = 2;
  localparam int TO = 8;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    s_req_valid;
  logic [NR-1:0]    s_req_ready;
  logic [NR*87-1:0] s_req;
  logic [NR-1:0]    s_resp_valid;
  logic [NR-1:0]    s_resp_ready;
  logic [50:0]      s_resp;
  logic             m_req_valid;
  logic             m_req_ready;
  logic [86:0]      m_req;
  logic             m_resp_valid;
  logic             m_resp_ready;
  logic [50:0]      m_resp;
  logic [1:0]       grant_o;
  logic             timeout_o;
  logic [1:0]       state_o;
  logic [1:0]       rr_ptr_o;

  mem_if_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req(s_req),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp(s_resp),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req(m_req),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready), .m_resp(m_resp),
    .grant_o(grant_o), .timeout_o(timeout_o), .state_o(state_o), .rr_ptr_o(rr_ptr_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  logic [86:0] pkt [NR];
  logic [86:0] exp_q[$];

  typedef struct {
    logic [1:0] valid;
    int         g;
    int         rdy_dly;
    int         rsp_dly;
    logic [1:0] rr_after;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [86:0] mk_pkt(input logic [2:0] typ, input logic [15:0] tid,
                                         input logic [31:0] addr, input logic [3:0] mask,
                                         input logic [31:0] data);
    return {typ, tid, addr, mask, data};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // IDLE -> SEND: winner gets ready this cycle, then is latched
  task automatic t_grant(input logic [1:0] v, input int g);
    logic [1:0] oh;
    oh = 2'(1 << g);
    s_req_valid = v;
    #1;
    chk("idle_state", state_o, ST_IDLE);
    chk("req_ready", s_req_ready, oh);
    exp_q.push_back(pkt[g]);
    step();
    chk("send_state", state_o, ST_SEND);
    chk("grant", grant_o, 2'(g));
    chk("send_ready0", s_req_ready, 2'b00);
  endtask

  // SEND: hold m_req_ready low for d cycles, then accept
  task automatic t_send(input int d);
    for (int i = 0; i < d; i++) begin
      m_req_ready = 1'b0;
      #1;
      chk("m_req_valid_hold", m_req_valid, 1'b1);
      step();
    end
    m_req_ready = 1'b1;
    #1;
    chk("m_req_valid", m_req_valid, 1'b1);
    if (exp_q.size() == 0) chk("m_req_sb_empty", 1'b1, 1'b0);
    else chk("m_req", m_req, exp_q.pop_front());
    step();
    m_req_ready = 1'b0;
    chk("wait_state", state_o, ST_WAIT);
  endtask

  // WAIT: response arrives after d silent cycles and is forwarded to g
  task automatic t_resp(input int g, input int d, input logic [1:0] rr_exp);
    logic [50:0] r;
    logic [1:0]  oh;
    oh = 2'(1 << g);
    r  = {pkt[g][86:84], pkt[g][83:68], 32'($urandom)};
    for (int i = 0; i < d; i++) begin
      m_resp_valid = 1'b0;
      #1;
      chk("resp_valid_idle", s_resp_valid, 2'b00);
      chk("wait_hold", state_o, ST_WAIT);
      step();
    end
    m_resp_valid = 1'b1;
    m_resp = r;
    #1;
    chk("resp_valid", s_resp_valid, oh);
    chk("s_resp", s_resp, r);
    chk("m_resp_ready", m_resp_ready, 1'b1);
    step();
    m_resp_valid = 1'b0;
    chk("back_idle", state_o, ST_IDLE);
    chk("rr_ptr", rr_ptr_o, rr_exp);
    chk("timeout_clear", timeout_o, 1'b0);
  endtask

  initial begin
    logic [50:0] r;
    pkt[0] = mk_pkt(3'd1, 16'h0012, 32'h0000_0100, 4'hF, 32'hCAFE_0001);
    pkt[1] = mk_pkt(3'd0, 16'h0345, 32'h0000_0200, 4'h3, 32'h0000_0000);
    s_req  = {pkt[1], pkt[0]};

    // valid, grant, ready delay, response delay, rr afterwards
    vecs[0] = '{2'b01, 0, 2, 3, 2'd1};
    vecs[1] = '{2'b11, 1, 0, 0, 2'd0};
    vecs[2] = '{2'b11, 0, 1, 2, 2'd1};
    vecs[3] = '{2'b11, 1, 0, 1, 2'd0};
    vecs[4] = '{2'b11, 0, 0, 0, 2'd1};
    vecs[5] = '{2'b01, 0, 1, 0, 2'd1};
    vecs[6] = '{2'b10, 1, 0, 2, 2'd0};
    vecs[7] = '{2'b10, 1, 2, 0, 2'd0};

    // reset with requests already pending: nothing may be accepted
    rst_i = 1'b1;
    s_req_valid = 2'b11;
    s_resp_ready = 2'b00;
    m_req_ready = 1'b0;
    m_resp_valid = 1'b0;
    m_resp = '0;
    step();
    step();
    chk("rst_state", state_o, ST_IDLE);
    chk("rst_req_ready", s_req_ready, 2'b00);
    chk("rst_grant", grant_o, 2'd0);
    chk("rst_rr", rr_ptr_o, 2'd0);
    chk("rst_m_req", m_req, 87'd0);
    chk("rst_m_req_valid", m_req_valid, 1'b0);
    chk("rst_timeout", timeout_o, 1'b0);
    rst_i = 1'b0;
    s_req_valid = 2'b00;
    s_resp_ready = 2'b11;
    step();

    for (int n = 0; n < 8; n++) begin
      t_grant(vecs[n].valid, vecs[n].g);
      t_send(vecs[n].rdy_dly);
      t_resp(vecs[n].g, vecs[n].rsp_dly, vecs[n].rr_after);
    end

    // no requests: stay idle
    s_req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("quiet_ready", s_req_ready, 2'b00);
      chk("quiet_state", state_o, ST_IDLE);
      step();
    end

    // response backpressure on requester 1; new requests must be ignored
    t_grant(2'b10, 1);
    t_send(0);
    r = {3'd0, 16'h0345, 32'h1234_5678};
    s_resp_ready = 2'b01;
    m_resp_valid = 1'b1;
    m_resp = r;
    s_req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_m_resp_ready", m_resp_ready, 1'b0);
      chk("bp_s_resp", s_resp, r);
      chk("bp_valid", s_resp_valid, 2'b10);
      chk("bp_state", state_o, ST_WAIT);
      chk("bp_req_ready", s_req_ready, 2'b00);
      chk("bp_grant", grant_o, 2'd1);
      step();
    end
    s_resp_ready = 2'b11;
    #1;
    chk("bp_release", m_resp_ready, 1'b1);
    step();
    m_resp_valid = 1'b0;
    s_req_valid = 2'b00;
    chk("bp_idle", state_o, ST_IDLE);
    chk("bp_rr", rr_ptr_o, 2'd0);

    // reset during WAIT of a requester-1 transaction, with rr_ptr at 1
    t_grant(2'b01, 0);
    t_send(0);
    t_resp(0, 0, 2'd1);
    t_grant(2'b10, 1);
    t_send(1);
    s_resp_ready = 2'b00;
    m_resp_valid = 1'b1;
    m_resp = {3'd0, 16'h0345, 32'h0BAD_0BAD};
    s_req_valid = 2'b11;
    #1;
    chk("pre_rst_valid", s_resp_valid, 2'b10);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_resp_valid", s_resp_valid, 2'b00);
    chk("mid_rst_s_resp", s_resp, 51'd0);
    chk("mid_rst_req_ready", s_req_ready, 2'b00);
    chk("mid_rst_m_req_valid", m_req_valid, 1'b0);
    chk("mid_rst_m_resp_ready", m_resp_ready, 1'b0);
    chk("mid_rst_m_req", m_req, 87'd0);
    chk("mid_rst_grant", grant_o, 2'd0);
    chk("mid_rst_rr", rr_ptr_o, 2'd0);
    chk("mid_rst_state", state_o, ST_IDLE);
    step();
    rst_i = 1'b0;
    m_resp_valid = 1'b0;
    s_resp_ready = 2'b11;
    t_grant(2'b11, 0);
    t_send(0);
    t_resp(0, 1, 2'd1);

`ifdef MEM_IF_ARB_TIMEOUT_EN
    // silent downstream: synthetic response after TO WAIT cycles
    t_grant(2'b01, 0);
    t_send(0);
    s_req_valid = 2'b00;
    for (int i = 0; i < TO - 1; i++) begin
      #1;
      chk("to_quiet", s_resp_valid, 2'b00);
      chk("to_wait", state_o, ST_WAIT);
      step();
    end
    #1;
    chk("to_valid", s_resp_valid, 2'b01);
    chk("to_resp", s_resp, {3'd7, 16'h0012, 32'hDEAD_BEEF});
    chk("to_m_resp_ready", m_resp_ready, 1'b0);
    step();
    chk("to_flag", timeout_o, 1'b1);
    chk("to_drop", state_o, ST_DROP);
    chk("to_rr", rr_ptr_o, 2'd1);
    m_resp_valid = 1'b1;
    m_resp = {3'd1, 16'h0012, 32'h5555_AAAA};
    #1;
    chk("drop_no_fwd", s_resp_valid, 2'b00);
    chk("drop_ready", m_resp_ready, 1'b1);
    step();
    m_resp_valid = 1'b0;
    chk("drop_idle", state_o, ST_IDLE);
    chk("to_sticky", timeout_o, 1'b1);
`else
    chk("no_timeout", timeout_o, 1'b0);
`endif

    if (exp_q.size() != 0) chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
